wb_result_fifo: RTL and testbench
=================================

# wb_result_fifo

Show-ahead FIFO that buffers 32-bit execution results together with their destination-select bit, and drives the data/select inputs of the downstream writeback demultiplexer. It decouples the producing stage from the writeback path. The execute stage can push one result per cycle while the writeback side drains at its own rate. Overflow and underflow are flagged sticky for debug.

## Interface
Parameters:
- `WIDTH`, 32: data width of each entry.
- `DEPTH`, 4: number of entries. Must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `push`, input, 1: write request from the execute stage.
- `push_data`, input, WIDTH: result to enqueue.
- `push_sel`, input, 1: destination select bit stored alongside the data.
- `pop`, input, 1: read request from the writeback side.
- `out_data`, output, WIDTH: head entry data. Feeds the demux data input.
- `out_sel`, output, 1: head entry select. Feeds the demux select.
- `out_valid`, output, 1: FIFO is non-empty, so `out_data`/`out_sel` are meaningful.
- `full`, output, 1: count == DEPTH.
- `count`, output, $clog2(DEPTH)+1: number of stored entries.
- `overflow`, output, 1: sticky. Set when a push is dropped.
- `underflow`, output, 1: sticky. Set when a pop hits an empty FIFO.
- `clr_err`, input, 1: synchronous clear of both sticky flags.

## Operation
- Storage: DEPTH entries of {sel, data}. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Accepted push: `push && (!full || pop)`. Writes the entry at wptr, then wptr+1.
- Accepted pop: `pop && out_valid`. Advances rptr by 1.
- Count update: count += accepted push − accepted pop.
- Push while full without pop: entry is dropped, there is no state change, and `overflow` is set.
- Push+pop while full: both are accepted, and count stays at DEPTH.
- Pop while empty: ignored and `underflow` is set. A simultaneous push is still accepted.
- Push+pop while empty: the push is accepted, the pop is ignored (underflow is set), and count becomes 1. There is no fall-through: the new entry appears next cycle.
- Show-ahead: `out_data`/`out_sel` continuously reflect the entry at rptr.
  - When empty, they hold the last-read value. The value is don't-care, but it must not be X after reset.
- `clr_err` clears the sticky flags. If an error event occurs in the same cycle, the error wins and the flag stays 1.

## Timing
- Reset (async assert, while `rst_n`=0):
  - `wptr`=`rptr`=0, `count`=0, `out_valid`=0, `full`=0, `overflow`=0, `underflow`=0.
  - All storage entries are cleared to 0, so `out_data`=0 and `out_sel`=0.
- Reset deassertion: the first edge that can update state is the first rising `clk` with `rst_n`=1.
- Reset asserted mid-operation: all contents are discarded immediately, with no completion of in-flight push/pop.
- Push→visible latency: 1 cycle. An entry pushed at edge N is on `out_data` with `out_valid`=1 after edge N.
- Pop→next head: the new head is visible after the same edge that accepts the pop.
- Derivation of `full`, `out_valid` and `count`:
  - `out_valid` and `full` are derived combinationally from the registered count.
  - `count` itself is a register. There is no combinational path from `push`/`pop` to `full` or `out_valid`.
- `out_data`/`out_sel` are combinational reads of the storage array indexed by registered `rptr`. This is the only combinational output path.
- Sustained throughput: 1 push and 1 pop per cycle.

## Structure
- Shared package holds:
  - `RESULT_W` = 32.
  - `WB_FIFO_DEPTH` = 4.
  - A typedef for the entry {sel, data}, shared by the execute and writeback stages.
- Natural sub-module: `wb_fifo_ptr`, a parameterised wrapping pointer/counter with an increment enable. Instantiate it twice, for wptr and rptr.
- Storage is an inferred register array. Do not use a RAM macro at this depth.

## Test plan
- Reset check: assert `rst_n`=0 mid-run with 3 entries held. The required response is:
  - Outputs are immediately `count`=0, `out_valid`=0, `out_data`=0, and both error flags are 0.
  - The next push of 0x0000_00AA is visible alone after 1 cycle.
- Fill and drain:
  - Push 0x1111_1111 (sel=1), 0x2222_2222 (sel=0), 0x3333_3333 (sel=1), 0x4444_4444 (sel=0). Required: `full`=1, `count`=4.
  - Pop 4 times. Required: the heads appear in order with matching sel, then `out_valid`=0.
- Overflow:
  - With the FIFO full, push 0xDEAD_BEEF with no pop. Required: `overflow`=1, count stays 4, and 0xDEAD_BEEF is never popped.
  - Assert `clr_err`. Required: `overflow`=0.
- Full simultaneous push+pop: with the FIFO full, push 0x5555_5555 and pop in the same cycle. Required:
  - Count stays 4 and the head advances.
  - 0x5555_5555 emerges as the 4th subsequent pop.
- Empty pop + push: with the FIFO empty, pop and push 0x0000_0007 (sel=1) in the same cycle. Required:
  - `underflow`=1 and `count`=1.
  - Next cycle `out_data`=0x0000_0007, `out_sel`=1.
- Wrap-around streaming: 20 cycles of simultaneous push/pop with an incrementing pattern 0..19 after priming with one entry. Required:
  - Output order is preserved across multiple pointer wraps.
  - Count stays 1 and there are no error flags.

Source files
------------

// File: rtl/wb_result_fifo_pkg.sv
// rtl/wb_result_fifo_pkg.sv - shared result width, FIFO depth and result-entry type
package wb_result_fifo_pkg;

  localparam int RESULT_W      = 32;
  localparam int WB_FIFO_DEPTH = 4;

  // One buffered execution result: destination select plus data.
  typedef struct packed {
    logic                sel;
    logic [RESULT_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_ptr.sv
// rtl/wb_fifo_ptr.sv - wrapping pointer with increment enable
module wb_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] ONE = 1;

  // DEPTH is a power of two, so plain overflow of the AW-bit register is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ONE;
    end
  end

endmodule

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - show-ahead result FIFO feeding the writeback demux
module wb_result_fifo
  import wb_result_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_sel,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel,
  output logic                     out_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = 1;

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && out_valid;

  assign out_data  = mem[rptr][WIDTH-1:0];
  assign out_sel   = mem[rptr][WIDTH];

  wb_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_push),
    .ptr   (wptr)
  );

  wb_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_pop),
    .ptr   (rptr)
  );

  // Storage is cleared on reset so the show-ahead outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wptr] <= {push_sel, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + ONE_C;
    end else if (do_pop && !do_push) begin
      count <= count - ONE_C;
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop && !out_valid) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_result_fifo.sv
// tb/tb_wb_result_fifo.sv - self-checking bench for wb_result_fifo
module tb_wb_result_fifo;
  import wb_result_fifo_pkg::*;

  localparam int D = WB_FIFO_DEPTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                push = 1'b0;
  logic [RESULT_W-1:0] push_data = '0;
  logic                push_sel = 1'b0;
  logic                pop = 1'b0;
  logic                clr_err = 1'b0;
  logic [RESULT_W-1:0] out_data;
  logic                out_sel;
  logic                out_valid;
  logic                full;
  logic [$clog2(D):0]  count;
  logic                overflow;
  logic                underflow;

  int vectors = 0;
  int miscompares = 0;

  wb_entry_t mq[$];
  bit        m_ovf = 1'b0;
  bit        m_unf = 1'b0;

  always #5 clk = ~clk;

  wb_result_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .push_sel  (push_sel),
    .pop       (pop),
    .clr_err   (clr_err),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic        p;
    logic [31:0] d;
    logic        s;
    logic        po;
    logic        ce;
    int          e_count;
    logic        e_valid;
    logic        e_full;
    logic [31:0] e_data;
    logic        e_sel;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0].data);
      chk("out_sel", 32'(out_sel), 32'(mq[0].sel));
    end
  endtask

  // Applies one cycle of inputs, advances the reference model, checks after the edge.
  task automatic cyc(input logic p, input logic [31:0] d, input logic s,
                     input logic po, input logic ce);
    int n;
    bit ap, apo;
    push = p; push_data = d; push_sel = s; pop = po; clr_err = ce;
    @(posedge clk);
    n   = mq.size();
    ap  = p && (n < D || po);
    apo = po && (n > 0);
    if (p && n == D && !po) m_ovf = 1'b1;
    else if (ce)            m_ovf = 1'b0;
    if (po && n == 0)       m_unf = 1'b1;
    else if (ce)            m_unf = 1'b0;
    if (apo) void'(mq.pop_front());
    if (ap) mq.push_back('{sel: s, data: d});
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    check_model();
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    //        p   data           s   po  ce  cnt val full head           sel ovf unf
    tbl[0] = '{1, 32'h1111_1111, 1, 0, 0, 1, 1, 0, 32'h1111_1111, 1, 0, 0};
    tbl[1] = '{1, 32'h2222_2222, 0, 0, 0, 2, 1, 0, 32'h1111_1111, 1, 0, 0};
    tbl[2] = '{1, 32'h3333_3333, 1, 0, 0, 3, 1, 0, 32'h1111_1111, 1, 0, 0};
    tbl[3] = '{1, 32'h4444_4444, 0, 0, 0, 4, 1, 1, 32'h1111_1111, 1, 0, 0};
    tbl[4] = '{1, 32'hDEAD_BEEF, 1, 0, 0, 4, 1, 1, 32'h1111_1111, 1, 1, 0};
    tbl[5] = '{0, 32'h0,         0, 0, 1, 4, 1, 1, 32'h1111_1111, 1, 0, 0};
    tbl[6] = '{0, 32'h0,         0, 1, 0, 3, 1, 0, 32'h2222_2222, 0, 0, 0};
    tbl[7] = '{0, 32'h0,         0, 1, 0, 2, 1, 0, 32'h3333_3333, 1, 0, 0};
    tbl[8] = '{0, 32'h0,         0, 1, 0, 1, 1, 0, 32'h4444_4444, 0, 0, 0};
    tbl[9] = '{0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0};

    // Reset state
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Fill, overflow, clear, drain
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].p, tbl[i].d, tbl[i].s, tbl[i].po, tbl[i].ce);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].e_unf));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_sel", i), 32'(out_sel), 32'(tbl[i].e_sel));
      end
    end

    // Full simultaneous push+pop
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(i), i[0], 1'b0, 1'b0);
    cyc(1'b1, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
    chk("fpp_count", 32'(count), 32'd4);
    chk("fpp_head", out_data, 32'h101);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("fpp_4th_head", out_data, 32'h5555_5555);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("fpp_empty", 32'(out_valid), 32'd0);

    // Empty pop + push
    cyc(1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    chk("epp_unf", 32'(underflow), 32'd1);
    chk("epp_count", 32'(count), 32'd1);
    chk("epp_data", out_data, 32'h7);
    chk("epp_sel", 32'(out_sel), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("epp_clr", 32'(underflow), 32'd0);

    // Wrap-around streaming
    cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wrap%0d_head", i), out_data, (i == 0) ? 32'h100 : 32'(i - 1));
      cyc(1'b1, 32'(i), i[1], 1'b1, 1'b0);
      chk($sformatf("wrap%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("wrap%0d_flags", i), 32'({overflow, underflow}), 32'd0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom),
          1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
    end

    // Asynchronous reset mid-operation with 3 entries held and a flag set
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    while (mq.size() != 0) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_sel", 32'(out_sel), 32'd0);
    chk("arst_flags", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_data", out_data, 32'hAA);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
